// File: rtl/write_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : write_burst_arbiter
// Purpose  : Two-requester write-burst arbiter that hands a write master to
//            one requester for a whole burst. Optional WRARB_ROUND_ROBIN_EN
//            macro selects round-robin instead of fixed r0 priority.
// Revision : 1.0 - initial release
// ============================================================================
module write_burst_arbiter #(
    parameter int DATA_W    = 512,
    parameter int MAX_LINES = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] r0_data_i,
    input  logic              r0_req_i,
    input  logic              r0_first_i,
    input  logic              r0_last_i,
    output logic              r0_ack_o,
    output logic              r0_done_o,
    input  logic [DATA_W-1:0] r1_data_i,
    input  logic              r1_req_i,
    input  logic              r1_first_i,
    input  logic              r1_last_i,
    output logic              r1_ack_o,
    output logic              r1_done_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_req_o,
    output logic              m_first_o,
    output logic              m_last_o,
    input  logic              m_ack_i,
    input  logic              m_done_i,
    output logic [1:0]        grant_o,
    output logic              err_o,
    input  logic              err_clr_i
);

    localparam int               CNT_W = $clog2(MAX_LINES) + 1;
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_LINES);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_owner;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_grant;
    logic             r_done0;
    logic             r_done1;
    logic             r_err;

    logic             w_elig0;
    logic             w_elig1;
    logic             w_sel;
    logic             w_in_grant;
    logic             w_hs;
    logic             w_err_set;

    assign w_elig0    = r0_req_i & r0_first_i;
    assign w_elig1    = r1_req_i & r1_first_i;
    assign w_in_grant = (r_state == ST_GRANT);

`ifdef WRARB_ROUND_ROBIN_EN
    // r_prio = 1 means r1 is preferred on a tie (r0 was served last)
    logic r_prio;
    assign w_sel = (w_elig0 & w_elig1) ? r_prio : w_elig1;
`else
    assign w_sel = w_elig1 & ~w_elig0;
`endif

    always_comb begin
        m_data_o  = '0;
        m_req_o   = 1'b0;
        m_first_o = 1'b0;
        m_last_o  = 1'b0;
        if (w_in_grant) begin
            m_data_o  = r_owner ? r1_data_i  : r0_data_i;
            m_req_o   = r_owner ? r1_req_i   : r0_req_i;
            m_first_o = r_owner ? r1_first_i : r0_first_i;
            m_last_o  = r_owner ? r1_last_i  : r0_last_i;
        end
    end

    assign r0_ack_o  = w_in_grant & ~r_owner & m_ack_i;
    assign r1_ack_o  = w_in_grant &  r_owner & m_ack_i;
    assign w_hs      = m_req_o & m_ack_i;

    // A repeated first marker is only detectable once the burst has moved on
    assign w_err_set = w_hs & (((r_count == C_MAX) & ~m_last_o) |
                               (m_first_o & (r_count != '0)));

    assign grant_o   = r_grant;
    assign r0_done_o = r_done0;
    assign r1_done_o = r_done1;
    assign err_o     = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_count <= '0;
            r_grant <= 2'b00;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;
`ifdef WRARB_ROUND_ROBIN_EN
            r_prio  <= 1'b0;
`endif
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_elig0 | w_elig1) begin
                        r_state <= ST_GRANT;
                        r_owner <= w_sel;
                        r_grant <= w_sel ? 2'b10 : 2'b01;
                        r_count <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_hs) begin
                        if (r_count != C_MAX) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                        if (m_last_o) begin
                            r_state <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (m_done_i) begin
                        r_state <= ST_IDLE;
                        r_grant <= 2'b00;
                        r_done0 <= ~r_owner;
                        r_done1 <=  r_owner;
`ifdef WRARB_ROUND_ROBIN_EN
                        r_prio  <= ~r_owner;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_write_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_burst_arbiter
// Purpose  : Directed self-checking bench for write_burst_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_burst_arbiter;

    localparam int DATA_W = 32;
`ifdef WRARB_ROUND_ROBIN_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] r0_data, r1_data, m_data;
    logic              r0_req, r0_first, r0_last, r0_ack, r0_done;
    logic              r1_req, r1_first, r1_last, r1_ack, r1_done;
    logic              m_req, m_first, m_last, m_ack, m_done;
    logic [1:0]        grant;
    logic              err, err_clr;

    int vectors = 0;
    int miscompares = 0;

    write_burst_arbiter #(.DATA_W(DATA_W), .MAX_LINES(4)) dut (
        .clk(clk), .rst(rst),
        .r0_data_i(r0_data), .r0_req_i(r0_req), .r0_first_i(r0_first),
        .r0_last_i(r0_last), .r0_ack_o(r0_ack), .r0_done_o(r0_done),
        .r1_data_i(r1_data), .r1_req_i(r1_req), .r1_first_i(r1_first),
        .r1_last_i(r1_last), .r1_ack_o(r1_ack), .r1_done_o(r1_done),
        .m_data_o(m_data), .m_req_o(m_req), .m_first_o(m_first),
        .m_last_o(m_last), .m_ack_i(m_ack), .m_done_i(m_done),
        .grant_o(grant), .err_o(err), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        r0_data = '0; r0_req = 0; r0_first = 0; r0_last = 0;
        r1_data = '0; r1_req = 0; r1_first = 0; r1_last = 0;
        m_ack = 0; m_done = 0; err_clr = 0;
        cyc();
        cyc();
        chk("rst_grant", grant, 2'b00);
        chk("rst_mreq", m_req, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ack0", r0_ack, 1'b0);
        rst = 1'b0;

        // r0 three-line burst, master always ready
        r0_req = 1; r0_first = 1; r0_data = 32'hA1; m_ack = 1;
        settle();
        chk("idle_grant", grant, 2'b00);
        chk("idle_ack0", r0_ack, 1'b0);
        chk("idle_mreq", m_req, 1'b0);
        cyc();
        chk("b1_grant", grant, 2'b01);
        chk("b1_mreq", m_req, 1'b1);
        chk("b1_mfirst", m_first, 1'b1);
        chk("b1_mdata", m_data, 32'hA1);
        chk("b1_ack0", r0_ack, 1'b1);
        cyc();
        r0_first = 0; r0_data = 32'hA2;
        settle();
        chk("b2_mdata", m_data, 32'hA2);
        chk("b2_mfirst", m_first, 1'b0);
        chk("b2_ack0", r0_ack, 1'b1);
        cyc();
        r0_data = 32'hA3; r0_last = 1;
        settle();
        chk("b3_mlast", m_last, 1'b1);
        chk("b3_ack0", r0_ack, 1'b1);
        cyc();
        r0_req = 0; r0_last = 0;
        settle();
        chk("wd_mreq", m_req, 1'b0);
        chk("wd_ack0", r0_ack, 1'b0);
        chk("wd_grant", grant, 2'b01);
        m_done = 1;
        settle();
        chk("wd_done_early", r0_done, 1'b0);
        cyc();
        m_done = 0;
        chk("done0_pulse", r0_done, 1'b1);
        chk("done_idle_grant", grant, 2'b00);
        cyc();
        chk("done0_single", r0_done, 1'b0);

        // m_done in IDLE is ignored
        m_done = 1;
        cyc();
        cyc();
        chk("idle_mdone_r0", r0_done, 1'b0);
        chk("idle_mdone_r1", r1_done, 1'b0);
        m_done = 0;

        // request without first is neither acked nor granted
        r1_req = 1; r1_data = 32'hB0;
        cyc();
        cyc();
        chk("nofirst_grant", grant, 2'b00);
        chk("nofirst_ack1", r1_ack, 1'b0);
        chk("nofirst_mreq", m_req, 1'b0);
        r1_req = 0;

        // simultaneous first requests, twice in a row
        do_reset();
        r0_req = 1; r0_first = 1; r0_last = 1; r0_data = 32'hC0;
        r1_req = 1; r1_first = 1; r1_last = 1; r1_data = 32'hD0;
        m_ack = 1;
        cyc();
        chk("tie1_grant", grant, 2'b01);
        chk("tie1_mdata", m_data, 32'hC0);
        chk("tie1_ack1", r1_ack, 1'b0);
        cyc();
        r0_data = 32'hC1;
        m_done = 1;
        cyc();
        m_done = 0;
        chk("tie1_done0", r0_done, 1'b1);
        cyc();
        chk("tie2_grant", grant, RR ? 2'b10 : 2'b01);
        chk("tie2_mdata", m_data, RR ? 32'hD0 : 32'hC1);
        cyc();
        r0_req = 0; r1_req = 0;
        m_done = 1;
        cyc();
        m_done = 0;
        chk("tie2_done1", r1_done, RR ? 1'b1 : 1'b0);
        chk("tie2_done0", r0_done, RR ? 1'b0 : 1'b1);
        cyc();

        // r1 held off during stalled r0 burst
        r0_req = 1; r0_first = 1; r0_last = 1; r0_data = 32'hE0;
        r1_req = 0;
        m_ack = 0;
        cyc();
        r1_req = 1; r1_first = 1; r1_last = 1; r1_data = 32'hF0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("stall_ack1", r1_ack, 1'b0);
            chk("stall_ack0", r0_ack, 1'b0);
            chk("stall_mdata", m_data, 32'hE0);
            cyc();
        end
        m_ack = 1;
        settle();
        chk("unstall_ack0", r0_ack, 1'b1);
        chk("unstall_ack1", r1_ack, 1'b0);
        cyc();
        r0_req = 0;
        m_done = 1;
        settle();
        chk("hold_wd_ack1", r1_ack, 1'b0);
        cyc();
        m_done = 0;
        chk("hold_done0", r0_done, 1'b1);
        chk("hold_done1", r1_done, 1'b0);
        cyc();
        chk("r1_grant", grant, 2'b10);
        chk("r1_mdata", m_data, 32'hF0);
        chk("r1_ack", r1_ack, 1'b1);
        cyc();
        r1_req = 0; r1_first = 0; r1_last = 0;
        m_done = 1;
        cyc();
        m_done = 0;
        chk("r1_done", r1_done, 1'b1);

        // line-count overflow with MAX_LINES = 4
        r0_req = 1; r0_first = 1; r0_last = 0; r0_data = 32'h100;
        m_ack = 1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            r0_first = (i == 0);
            r0_data = 32'h100 + i;
            settle();
            cyc();
            chk("ovf_err", err, (i == 4) ? 1'b1 : 1'b0);
        end
        r0_req = 0;
        cyc();
        chk("ovf_sticky", err, 1'b1);
        err_clr = 1;
        cyc();
        err_clr = 0;
        chk("ovf_clr", err, 1'b0);
        // first on a non-first line, with a clear in the same cycle
        r0_req = 1; r0_first = 1; r0_last = 1;
        err_clr = 1;
        settle();
        cyc();
        err_clr = 0;
        chk("dupfirst_err", err, 1'b1);
        r0_req = 0; r0_first = 0; r0_last = 0;
        m_done = 1;
        cyc();
        m_done = 0;
        chk("dupfirst_sticky", err, 1'b1);
        err_clr = 1;
        cyc();
        err_clr = 0;
        chk("dupfirst_clr", err, 1'b0);

        // reset in the middle of a burst
        r0_req = 1; r0_first = 1; r0_last = 0; r0_data = 32'h200;
        m_ack = 1;
        cyc();
        cyc();
        r0_first = 0; r0_data = 32'h201;
        settle();
        chk("mid_mdata", m_data, 32'h201);
        rst = 1;
        settle();
        chk("arst_mreq", m_req, 1'b0);
        chk("arst_grant", grant, 2'b00);
        chk("arst_ack0", r0_ack, 1'b0);
        chk("arst_mdata", m_data, 32'h0);
        cyc();
        rst = 0;
        cyc();
        cyc();
        chk("retry_nofirst_grant", grant, 2'b00);
        chk("retry_nofirst_ack0", r0_ack, 1'b0);
        r0_first = 1;
        cyc();
        chk("retry_grant", grant, 2'b01);
        chk("retry_ack0", r0_ack, 1'b1);
        chk("retry_mfirst", m_first, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/write_burst_arbiter.md
WRITE_BURST_ARBITER -- requirements
Module: write_burst_arbiter

Interface
REQ-001 Parameter DATA_W, default 512, width of line data on every data port.
REQ-002 Parameter MAX_LINES, default 512, maximum legal lines per burst; line counter width is clog2(MAX_LINES)+1.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 r0_data_i / r1_data_i  in  DATA_W  requester 0/1 line data.
REQ-006 r0_req_i / r1_req_i  in  1  requester 0/1 line valid; held until acked.
REQ-007 r0_first_i / r1_first_i  in  1  line is first of burst.
REQ-008 r0_last_i / r1_last_i  in  1  line is last of burst.
REQ-009 r0_ack_o / r1_ack_o  out  1  line accepted this cycle.
REQ-010 r0_done_o / r1_done_o  out  1  one-cycle pulse, burst fully written.
REQ-011 m_data_o  out  DATA_W  line data to write master.
REQ-012 m_req_o / m_first_o / m_last_o  out  1  request/first/last to write master.
REQ-013 m_ack_i  in  1  write master accepted line (req & ~waitrequest).
REQ-014 m_done_i  in  1  write master burst complete.
REQ-015 grant_o  out  2  one-hot owner: bit0 = r0, bit1 = r1, 00 = none.
REQ-016 err_o  out  1  sticky protocol error flag.
REQ-017 err_clr_i  in  1  synchronous clear of err_o.

Function
REQ-018 FSM states IDLE, GRANT, WAIT_DONE; owner register selects r0 or r1 in GRANT/WAIT_DONE.
REQ-019 IDLE: a requester is eligible only if rX_req_i & rX_first_i; arbitration result registered, GRANT entered next cycle (1-cycle grant latency).
REQ-020 IDLE: all m_* outputs 0, both acks 0, grant_o = 00.
REQ-021 GRANT: m_data_o/m_req_o/m_first_o/m_last_o combinationally follow owner's inputs; owner ack = m_ack_i; non-owner ack held 0.
REQ-022 Line counter clears on GRANT entry, increments on m_req_o & m_ack_i, saturates at MAX_LINES.
REQ-023 Handshake (m_req_o & m_ack_i) with m_last_o = 1 moves GRANT -> WAIT_DONE.
REQ-024 WAIT_DONE: m_req_o = 0, both acks 0; m_done_i = 1 pulses owner's rX_done_o for one cycle and returns to IDLE same edge.
REQ-025 m_done_i outside WAIT_DONE is ignored.
REQ-026 err_o sets when: handshake occurs with counter already at MAX_LINES and no last; or owner presents first_i on a non-first line of its burst.
REQ-027 err_o does not alter sequencing; err_clr_i clears it, set wins over simultaneous clear.
REQ-028 Requests from the non-owner are held off (ack 0) without loss; they are re-evaluated in the next IDLE.
REQ-029 Request without first in IDLE is not acked and not granted.

Reset
REQ-030 rst asserted at any time, including mid-burst: FSM -> IDLE, counter 0, owner/priority pointer -> r0, err_o 0, all outputs 0 asynchronously.
REQ-031 After rst deasserts, first grant follows REQ-019; an interrupted burst must restart with first.

Configuration
REQ-032 Macro WRARB_ROUND_ROBIN_EN defined: on simultaneous eligible requests, grant the requester not served last; pointer updates at done pulse; reset pointer favours r0.
REQ-033 Macro undefined: fixed priority, r0 always wins simultaneous requests; no pointer register.

Verification
REQ-034 r0 3-line burst (first on line 1, last on line 3), m_ack_i always 1 -> grant_o 01 one cycle after req, 3 acks, m_done_i -> r0_done_o single pulse, back to IDLE.
REQ-035 r0 and r1 both first in same cycle, twice in a row with RR enabled -> grants r0 then r1; RR disabled -> r0 then r0.
REQ-036 r1 requests during r0 burst with m_ack_i stalled 4 cycles -> r1_ack_o stays 0, r1 granted after r0_done_o, no r1 data lost.
REQ-037 MAX_LINES=4, r0 sends 5 lines without last -> err_o 1 on 5th handshake, stays 1 until err_clr_i.
REQ-038 rst asserted on 2nd line of r0 burst -> outputs 0 immediately; r0 retry without first ignored, with first granted.
